// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Widest divisor field the helper functions accept.
  localparam int unsigned DIV_W_MAX = 16;
  localparam int unsigned MIN_DIV   = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Divisors of 0 or 1 would give a zero-length half period; force them to 2.
  function automatic logic [DIV_W_MAX-1:0] div_clamp(input logic [DIV_W_MAX-1:0] div);
    return (div < DIV_W_MAX'(MIN_DIV)) ? DIV_W_MAX'(MIN_DIV) : div;
  endfunction

  // High-phase length ceil(div/2), computed without overflowing the field width.
  function automatic logic [DIV_W_MAX-1:0] div_hi(input logic [DIV_W_MAX-1:0] div);
    return (div >> 1) + {{(DIV_W_MAX-1){1'b0}}, div[0]};
  endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divided-clock channel: divisor, phase counter and registered clock output,
// stepped by run/drain/load strobes from the top-level FSM.
module clock_divider_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned            p_div_bits  = 4,
  parameter logic [p_div_bits-1:0]  p_reset_div = p_div_bits'(2)
) (
  input  logic                  clk,
  input  logic                  clk_reset,
  input  logic                  run,
  input  logic                  drain,
  input  logic                  load,
  input  logic [p_div_bits-1:0] load_div,
  output logic                  clk_out,
  output logic [p_div_bits-1:0] div,
  output logic                  parked,
  output logic                  wrap_next
);

  localparam logic [p_div_bits-1:0] ONE     = p_div_bits'(1);
  localparam logic [p_div_bits-1:0] RST_DIV =
    p_div_bits'(div_clamp(DIV_W_MAX'(p_reset_div)));

  logic [p_div_bits-1:0] div_q, div_d;
  logic [p_div_bits-1:0] cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic [p_div_bits-1:0] cnt_n;
  logic [p_div_bits-1:0] hi;
  logic [p_div_bits-1:0] new_div;

  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    hi        = p_div_bits'(div_hi(DIV_W_MAX'(div_q)));
    new_div   = p_div_bits'(div_clamp(DIV_W_MAX'(load_div)));
    cnt_n     = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
    parked    = (cnt_q == div_q - ONE);
    wrap_next = (cnt_n == '0);

    if (load) begin
      div_d = new_div;
      cnt_d = new_div - ONE;
      out_d = 1'b0;
    end else if (drain) begin
      // A channel at the end of its period holds there, low, until reload.
      if (parked) begin
        out_d = 1'b0;
      end else begin
        cnt_d = cnt_n;
        out_d = (cnt_n < hi);
      end
    end else if (run) begin
      cnt_d = cnt_n;
      out_d = (cnt_n < hi);
    end
  end

  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      div_q <= RST_DIV;
      cnt_q <= RST_DIV - ONE;
      out_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign clk_out = out_q;
  assign div     = div_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel phase-aligned clock divider with glitch-free runtime divisor
// reconfiguration (drain all channels low, reload, restart together).
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned                   p_nchan      = 3,
  parameter int unsigned                   p_div_bits   = 4,
  parameter logic [p_nchan*p_div_bits-1:0] p_reset_divs = {4'd9, 4'd3, 4'd2}
) (
  input  logic                          clk,
  input  logic                          clk_reset,
  input  logic                          cfg_val,
  output logic                          cfg_rdy,
  input  logic [p_nchan*p_div_bits-1:0] cfg_divs,
  output logic [p_nchan-1:0]            clk_divided,
  output logic [p_nchan*p_div_bits-1:0] cur_divs,
  output logic                          sync_pulse,
  output logic                          busy
);

  localparam int unsigned VEC_W = p_nchan * p_div_bits;

  if (p_div_bits > DIV_W_MAX || p_div_bits < 2) begin : g_bad_width
    $error("multi_clock_divider: p_div_bits out of supported range");
  end

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   pend_q, pend_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               sync_q, sync_d;

  logic               chan_run;
  logic               chan_drain;
  logic               chan_load;
  logic [p_nchan-1:0] parked;
  logic [p_nchan-1:0] wrap_next;

  for (genvar c = 0; c < p_nchan; c++) begin : g_chan
    clock_divider_chan #(
      .p_div_bits  (p_div_bits),
      .p_reset_div (p_reset_divs[c*p_div_bits +: p_div_bits])
    ) u_chan (
      .clk       (clk),
      .clk_reset (clk_reset),
      .run       (chan_run),
      .drain     (chan_drain),
      .load      (chan_load),
      .load_div  (pend_q[c*p_div_bits +: p_div_bits]),
      .clk_out   (clk_divided[c]),
      .div       (cur_divs[c*p_div_bits +: p_div_bits]),
      .parked    (parked[c]),
      .wrap_next (wrap_next[c])
    );
  end

  // Reconfiguration FSM: RUN -(fire)-> DRAIN -(all parked)-> LOAD -> RUN.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    sync_d     = 1'b0;
    chan_run   = 1'b0;
    chan_drain = 1'b0;
    chan_load  = 1'b0;

    case (state_q)
      ST_RUN: begin
        chan_run = 1'b1;
        sync_d   = &wrap_next;
        if (cfg_val && rdy_q) begin
          pend_d  = cfg_divs;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        chan_drain = 1'b1;
        if (&parked) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        chan_load = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    rdy_d  = (state_d == ST_RUN);
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      state_q <= ST_RUN;
      pend_q  <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
    end
  end

  assign cfg_rdy    = rdy_q;
  assign busy       = busy_q;
  assign sync_pulse = sync_q;

endmodule
